// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// The state encoding, the frame sync byte, command opcodes and response status codes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CSUM,
        ST_EXEC,
        ST_TX_STATUS,
        ST_TX_VALUE
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_TOGGLE = 8'h03;

    localparam logic [7:0] STATUS_OK       = 8'h00;
    localparam logic [7:0] STATUS_BAD_CSUM = 8'h01;
    localparam logic [7:0] STATUS_BAD_CMD  = 8'h02;
    localparam logic [7:0] STATUS_RX_ERR   = 8'h03;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_TOGGLE);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level RX/TX handshake and LED/status signals of the command controller.
// The slave modport is the controller's view; master is the view of whoever drives it.
interface uart_cmd_ctrl_if;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [7:0] led;
    logic       busy;

    modport slave (
        input  rx_valid, rx_error, rx_data, tx_ready,
        output tx_valid, tx_data, led, busy
    );

    modport master (
        output rx_valid, rx_error, rx_data, tx_ready,
        input  tx_valid, tx_data, led, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES is reached (saturates there).
module gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != CW'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (r_count == CW'(TIMEOUT_CYCLES));
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames RX bytes into SYNC/CMD/DATA/CSUM commands, executes LED write/read/toggle
// and returns a STATUS/VALUE response pair on the TX handshake.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.slave  bus
);
    localparam int unsigned TIMEOUT_CYCLES = CLOCK_RATE / 1000000 * TIMEOUT_US;

    state_t     r_state,    w_state;
    logic [7:0] r_cmd,      w_cmd;
    logic [7:0] r_data,     w_data;
    logic [7:0] r_csum,     w_csum;
    logic       r_rx_err,   w_rx_err;
    logic [7:0] r_led,      w_led;
    logic       r_tx_valid, w_tx_valid;
    logic [7:0] r_tx_data,  w_tx_data;
    logic       r_busy,     w_busy;

    logic       w_in_get;
    logic       w_byte_taken;
    logic       w_gap_expired;
    logic [7:0] w_status;

    gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_get || w_byte_taken),
        .enable  (w_in_get),
        .expired (w_gap_expired)
    );

    // Status priority: framing error, then checksum, then opcode.
    always_comb begin
        w_status = STATUS_OK;
        if (r_rx_err) begin
            w_status = STATUS_RX_ERR;
        end else if ((r_cmd ^ r_data) != r_csum) begin
            w_status = STATUS_BAD_CSUM;
        end else if (!cmd_known(r_cmd)) begin
            w_status = STATUS_BAD_CMD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_data     <= 8'h00;
            r_csum     <= 8'h00;
            r_rx_err   <= 1'b0;
            r_led      <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cmd      <= w_cmd;
            r_data     <= w_data;
            r_csum     <= w_csum;
            r_rx_err   <= w_rx_err;
            r_led      <= w_led;
            r_tx_valid <= w_tx_valid;
            r_tx_data  <= w_tx_data;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cmd        = r_cmd;
        w_data       = r_data;
        w_csum       = r_csum;
        w_rx_err     = r_rx_err;
        w_led        = r_led;
        w_tx_valid   = r_tx_valid;
        w_tx_data    = r_tx_data;
        w_in_get     = 1'b0;
        w_byte_taken = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid && !bus.rx_error && (bus.rx_data == SYNC_BYTE)) begin
                    w_state  = ST_GET_CMD;
                    w_rx_err = 1'b0;
                end
            end
            ST_GET_CMD, ST_GET_DATA, ST_GET_CSUM: begin
                w_in_get = 1'b1;
                // An arriving byte takes precedence over a simultaneous timeout.
                if (bus.rx_valid) begin
                    w_byte_taken = 1'b1;
                    if (bus.rx_error) begin
                        w_rx_err = 1'b1;
                        w_state  = ST_EXEC;
                    end else if (r_state == ST_GET_CMD) begin
                        w_cmd   = bus.rx_data;
                        w_state = ST_GET_DATA;
                    end else if (r_state == ST_GET_DATA) begin
                        w_data  = bus.rx_data;
                        w_state = ST_GET_CSUM;
                    end else begin
                        w_csum  = bus.rx_data;
                        w_state = ST_EXEC;
                    end
                end else if (w_gap_expired) begin
                    w_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_status == STATUS_OK) begin
                    if (r_cmd == CMD_WRITE) begin
                        w_led = r_data;
                    end else if (r_cmd == CMD_TOGGLE) begin
                        w_led = r_led ^ r_data;
                    end
                end
                w_tx_valid = 1'b1;
                w_tx_data  = w_status;
                w_state    = ST_TX_STATUS;
            end
            ST_TX_STATUS: begin
                if (bus.tx_ready) begin
                    w_tx_data = r_led;
                    w_state   = ST_TX_VALUE;
                end
            end
            ST_TX_VALUE: begin
                if (bus.tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = ST_IDLE;
                end
            end
            default: begin
                w_state    = ST_IDLE;
                w_tx_valid = 1'b0;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.led      = r_led;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: command frames, error statuses, gap timeout,
// TX back-pressure and asynchronous reset during a response.
module tb_uart_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .CLOCK_RATE (10000000),
        .TIMEOUT_US (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        bus.rx_error = err;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] csum);
        send_byte(8'hA5, 1'b0);
        send_byte(cmd, 1'b0);
        send_byte(data, 1'b0);
        send_byte(csum, 1'b0);
    endtask

    // Leaves the bench at a falling edge with tx_valid high, or records a timeout.
    task automatic wait_txv(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_txv"}, 8'(bus.tx_valid), 8'h01);
    endtask

    task automatic finish_resp(input string tag, input logic [7:0] st, input logic [7:0] val,
                               input logic [7:0] led_exp);
        chk({tag, "_status"}, bus.tx_data, st);
        chk({tag, "_led"}, bus.led, led_exp);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_txv2"}, 8'(bus.tx_valid), 8'h01);
        chk({tag, "_value"}, bus.tx_data, val);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_txv_off"}, 8'(bus.tx_valid), 8'h00);
        chk({tag, "_busy_off"}, 8'(bus.busy), 8'h00);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led", bus.led, 8'h00);
        chk("rst_txv", 8'(bus.tx_valid), 8'h00);
        chk("rst_txd", bus.tx_data, 8'h00);
        chk("rst_busy", 8'(bus.busy), 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // WRITE 0x3C
        send_frame(8'h01, 8'h3C, 8'h3D);
        wait_txv("wr");
        finish_resp("wr", 8'h00, 8'h3C, 8'h3C);

        // TOGGLE with 0xFF
        send_frame(8'h03, 8'hFF, 8'hFC);
        wait_txv("tog");
        finish_resp("tog", 8'h00, 8'hC3, 8'hC3);

        // READ
        send_frame(8'h02, 8'h00, 8'h02);
        wait_txv("rd");
        finish_resp("rd", 8'h00, 8'hC3, 8'hC3);

        // Bad checksum
        send_frame(8'h01, 8'h55, 8'h00);
        wait_txv("csum");
        finish_resp("csum", 8'h01, 8'hC3, 8'hC3);

        // Unknown command
        send_frame(8'h07, 8'h10, 8'h17);
        wait_txv("cmd");
        finish_resp("cmd", 8'h02, 8'hC3, 8'hC3);

        // Junk then a truncated frame left to time out
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        chk("to_busy_mid", 8'(bus.busy), 8'h01);
        repeat (15) @(negedge clk);
        chk("to_busy_end", 8'(bus.busy), 8'h00);
        chk("to_txv", 8'(bus.tx_valid), 8'h00);
        chk("to_led", bus.led, 8'hC3);
        @(posedge clk);
        #1;
        send_frame(8'h01, 8'h81, 8'h80);
        wait_txv("after_to");
        finish_resp("after_to", 8'h00, 8'h81, 8'h81);

        // Framing error on DATA byte under TX back-pressure
        bus.tx_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h55, 1'b1);
        wait_txv("rxerr");
        for (int i = 0; i < 20; i++) begin
            bus.rx_valid = (i == 5) || (i == 6);
            bus.rx_data  = 8'hA5;
            @(negedge clk);
            chk("stall_txv", 8'(bus.tx_valid), 8'h01);
            chk("stall_txd", bus.tx_data, 8'h03);
        end
        bus.rx_valid = 1'b0;
        finish_resp("rxerr", 8'h03, 8'h81, 8'h81);

        // Asynchronous reset while VALUE is stalled
        bus.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        send_frame(8'h02, 8'h00, 8'h02);
        wait_txv("rst_tx");
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        chk("rst_tx_value", bus.tx_data, 8'h81);
        chk("rst_tx_valid", 8'(bus.tx_valid), 8'h01);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_txv", 8'(bus.tx_valid), 8'h00);
        chk("arst_led", bus.led, 8'h00);
        chk("arst_busy", 8'(bus.busy), 8'h00);
        chk("arst_txd", bus.tx_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h03, 8'h0F, 8'h0C);
        wait_txv("post_rst");
        finish_resp("post_rst", 8'h00, 8'h0F, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
